decode_issue_ctrl: RTL and testbench

Issue controller for the LC3 decode stage: accepts fetched instructions and their next-PC values from fetch on a valid/ready handshake, buffers them in a small FIFO, and drives `dout`, `npc_in` and `enable_decode` into decode one instruction per cycle. It honours a downstream stall and a branch flush. Optionally, it inserts bubbles after indirect memory instructions. It sits between fetch and decode and replaces direct fetch-to-decode wiring.

---
 rtl/decode_issue_pkg.sv | 25 ++
 rtl/decode_issue_fifo.sv | 57 +++++
 rtl/decode_issue_ctrl.sv | 122 ++++++++++++
 tb/tb_decode_issue_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_issue_pkg.sv
// decode_issue_pkg: shared types and constants for the decode issue controller.
package decode_issue_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned PC_W    = 16;

  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_BUBBLE = 2'd2
  } state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    npc;
  } fifo_entry_t;

  function automatic logic is_ind_mem(input logic [INSTR_W-1:0] instr);
    return (instr[15:12] == OP_LDI) || (instr[15:12] == OP_STI);
  endfunction

endpackage

// File: rtl/decode_issue_fifo.sv
// decode_issue_fifo: DEPTH-entry synchronous FIFO of {instr, npc} entries.
// Ports: clock, reset (sync, active-low), push_i, pop_i, clear_i, din_i,
//        head_o (entry at read pointer), count_o, full_o, empty_o.
module decode_issue_fifo
  import decode_issue_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        push_i,
  input  logic        pop_i,
  input  logic        clear_i,
  input  fifo_entry_t din_i,
  output fifo_entry_t head_o,
  output logic [AW:0] count_o,
  output logic        full_o,
  output logic        empty_o
);

  fifo_entry_t   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          push_ok;
  logic          pop_ok;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o && !clear_i;
  assign pop_ok  = pop_i && !empty_o && !clear_i;

  always_ff @(posedge clock) begin
    if (!reset || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/decode_issue_ctrl.sv
// decode_issue_ctrl: buffers fetched {instr, npc} pairs and issues them into
// decode one per cycle, honouring stall and branch flush.
// Ports: clock, reset (sync, active-low); fetch_valid/fetch_instr/fetch_npc/
//        fetch_ready (fetch handshake); stall, flush; dout, npc_in,
//        enable_decode, issue_count (to decode).
// Optional: DECODE_ISSUE_BUBBLE_EN inserts MEM_BUBBLES idle cycles after LDI/STI.
module decode_issue_ctrl
  import decode_issue_pkg::*;
#(
  parameter int unsigned DEPTH       = 2,
  parameter int unsigned MEM_BUBBLES = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fetch_valid,
  input  logic [15:0] fetch_instr,
  input  logic [15:0] fetch_npc,
  output logic        fetch_ready,
  input  logic        stall,
  input  logic        flush,
  output logic [15:0] dout,
  output logic [15:0] npc_in,
  output logic        enable_decode,
  output logic [15:0] issue_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || MEM_BUBBLES < 1) begin : g_param_check
    $error("decode_issue_ctrl: DEPTH must be a power of two >= 2 and MEM_BUBBLES >= 1");
  end

  state_e      state_q;
  logic [15:0] dout_q;
  logic [15:0] npc_q;
  logic        en_q;
  logic [15:0] issue_count_q;
  logic [15:0] issue_count_d;

  fifo_entry_t push_entry;
  fifo_entry_t head;
  logic [AW:0] fifo_count_unused;
  logic        fifo_full;
  logic        fifo_empty;
  logic        push;
  logic        pop;

`ifdef DECODE_ISSUE_BUBBLE_EN
  localparam int unsigned BW = (MEM_BUBBLES > 1) ? $clog2(MEM_BUBBLES) : 1;
  logic [BW-1:0] bub_q;
`endif

  // fetch_ready depends on registered state only, never on this cycle's flush.
  assign fetch_ready = (state_q != ST_IDLE) && !fifo_full;
  assign push        = fetch_valid && fetch_ready && !flush;
  assign pop         = (state_q == ST_RUN) && !stall && !flush && !fifo_empty;

  assign push_entry.instr = fetch_instr;
  assign push_entry.npc   = fetch_npc;
  assign issue_count_d    = issue_count_q + 1'b1;

  decode_issue_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .clear_i (flush),
    .din_i   (push_entry),
    .head_o  (head),
    .count_o (fifo_count_unused),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      dout_q        <= '0;
      npc_q         <= '0;
      en_q          <= 1'b0;
      issue_count_q <= '0;
`ifdef DECODE_ISSUE_BUBBLE_EN
      bub_q         <= '0;
`endif
    end else begin
      en_q <= 1'b0;
      case (state_q)
        ST_IDLE: state_q <= ST_RUN;
        ST_RUN: begin
          if (pop) begin
            dout_q        <= head.instr;
            npc_q         <= head.npc;
            en_q          <= 1'b1;
            issue_count_q <= issue_count_d;
`ifdef DECODE_ISSUE_BUBBLE_EN
            // Counter holds remaining bubble cycles minus one.
            if (is_ind_mem(head.instr)) begin
              state_q <= ST_BUBBLE;
              bub_q   <= BW'(MEM_BUBBLES - 1);
            end
`endif
          end
        end
`ifdef DECODE_ISSUE_BUBBLE_EN
        ST_BUBBLE: begin
          if (flush || bub_q == '0) state_q <= ST_RUN;
          else                      bub_q   <= bub_q - 1'b1;
        end
`endif
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign dout          = dout_q;
  assign npc_in        = npc_q;
  assign enable_decode = en_q;
  assign issue_count   = issue_count_q;

endmodule

// File: tb/tb_decode_issue_ctrl.sv
module tb_decode_issue_ctrl;

  localparam int DEPTH = 2;
  localparam int MB    = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        fetch_valid = 1'b0;
  logic [15:0] fetch_instr = '0;
  logic [15:0] fetch_npc = '0;
  logic        fetch_ready;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] dout;
  logic [15:0] npc_in;
  logic        enable_decode;
  logic [15:0] issue_count;

  always #5 clock = ~clock;

  decode_issue_ctrl #(
    .DEPTH       (DEPTH),
    .MEM_BUBBLES (MB)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .fetch_valid   (fetch_valid),
    .fetch_instr   (fetch_instr),
    .fetch_npc     (fetch_npc),
    .fetch_ready   (fetch_ready),
    .stall         (stall),
    .flush         (flush),
    .dout          (dout),
    .npc_in        (npc_in),
    .enable_decode (enable_decode),
    .issue_count   (issue_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a queue of buffered entries plus a bubble countdown.
  typedef struct {
    logic [15:0] i;
    logic [15:0] n;
  } ent_t;

  ent_t        mq[$];
  bit          m_known = 0;
  bit          m_run = 0;
  int          m_bub = 0;
  logic [15:0] m_dout = '0;
  logic [15:0] m_npc = '0;
  logic [15:0] m_cnt = '0;
  bit          m_en = 0;

  task automatic step(input bit r, input bit v, input logic [15:0] ins,
                      input logic [15:0] nv, input bit st, input bit fl);
    bit   rdy;
    ent_t e;
    reset       = r;
    fetch_valid = v;
    fetch_instr = ins;
    fetch_npc   = nv;
    stall       = st;
    flush       = fl;
    rdy = m_run && (mq.size() < DEPTH);
    #1;
    if (m_known) chk("fetch_ready", 32'(fetch_ready), 32'(rdy));
    @(posedge clock);
    #1;
    if (!r) begin
      m_known = 1; m_run = 0; mq.delete(); m_bub = 0;
      m_dout = '0; m_npc = '0; m_en = 0; m_cnt = '0;
    end else if (m_known) begin
      m_en = 0;
      if (!m_run) m_run = 1;
      else if (fl) begin
        mq.delete();
        m_bub = 0;
      end else begin
        if (m_bub > 0) m_bub--;
        else if (!st && mq.size() > 0) begin
          e = mq.pop_front();
          m_dout = e.i; m_npc = e.n; m_en = 1; m_cnt = m_cnt + 16'd1;
`ifdef DECODE_ISSUE_BUBBLE_EN
          if (e.i[15:13] == 3'b101) m_bub = MB;
`endif
        end
        if (v && rdy) begin
          e.i = ins; e.n = nv;
          mq.push_back(e);
        end
      end
    end
    if (m_known) begin
      chk("dout", 32'(dout), 32'(m_dout));
      chk("npc_in", 32'(npc_in), 32'(m_npc));
      chk("enable_decode", 32'(enable_decode), 32'(m_en));
      chk("issue_count", 32'(issue_count), 32'(m_cnt));
    end
  endtask

  task automatic do_reset();
    step(0, 0, '0, '0, 0, 0);
    step(0, 0, '0, '0, 0, 0);
    step(1, 0, '0, '0, 0, 0);
  endtask

  typedef struct {
    bit          rst;
    bit          v;
    logic [15:0] ins;
    logic [15:0] nv;
    bit          st;
    bit          fl;
    bit          e_en;
    logic [15:0] e_dout;
    logic [15:0] e_npc;
    logic [15:0] e_cnt;
    bit          e_rdy;
  } vec_t;

  vec_t        tbl[6];
  logic [15:0] sins[5];
  logic [15:0] log_q[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int  t1, t2, sent, pulses;
    bit  saw_block, rdy_pre;

    // rst v ins npc st fl | en dout npc cnt rdy (post-edge)
    tbl[0] = '{0, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0};
    tbl[1] = '{0, 1, 16'h1021, 16'h3001, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 0};
    tbl[2] = '{1, 1, 16'h1021, 16'h3001, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1};
    tbl[3] = '{1, 1, 16'h1021, 16'h3001, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1};
    tbl[4] = '{1, 0, 16'h0000, 16'h0000, 0, 0, 1, 16'h1021, 16'h3001, 16'h0001, 1};
    tbl[5] = '{1, 0, 16'h0000, 16'h0000, 0, 0, 0, 16'h1021, 16'h3001, 16'h0001, 1};
    sins = '{16'h1001, 16'h2002, 16'h3003, 16'h5005, 16'h6006};

    for (int k = 0; k < 6; k++) begin
      step(tbl[k].rst, tbl[k].v, tbl[k].ins, tbl[k].nv, tbl[k].st, tbl[k].fl);
      chk("tbl_en", 32'(enable_decode), 32'(tbl[k].e_en));
      chk("tbl_dout", 32'(dout), 32'(tbl[k].e_dout));
      chk("tbl_npc", 32'(npc_in), 32'(tbl[k].e_npc));
      chk("tbl_count", 32'(issue_count), 32'(tbl[k].e_cnt));
      chk("tbl_ready", 32'(fetch_ready), 32'(tbl[k].e_rdy));
    end

    // Five back-to-back instructions, stall for three cycles.
    do_reset();
    sent = 0; saw_block = 0; log_q.delete();
    for (int c = 0; c < 30; c++) begin
      bit v, st;
      v  = (sent < 5);
      st = (c >= 1 && c <= 3);
      rdy_pre = m_run && (mq.size() < DEPTH);
      if (st && fetch_ready === 1'b0) saw_block = 1;
      step(1, v, v ? sins[sent] : 16'h0, 16'h3001 + 16'(sent), st, 0);
      if (v && rdy_pre) sent++;
      if (enable_decode === 1'b1) log_q.push_back(dout);
    end
    chk("stall_ready_drop", 32'(saw_block), 32'd1);
    chk("stall_n_issued", 32'(log_q.size()), 32'd5);
    for (int k = 0; k < 5 && k < log_q.size(); k++) chk("stall_order", 32'(log_q[k]), 32'(sins[k]));
    chk("stall_issue_count", 32'(issue_count), 32'd5);

    // Flush with two buffered entries and fetch_valid high.
    do_reset();
    step(1, 1, 16'h1111, 16'h4001, 1, 0);
    step(1, 1, 16'h2222, 16'h4002, 1, 0);
    chk("flush_full_ready", 32'(fetch_ready), 32'd0);
    step(1, 1, 16'h3333, 16'h4003, 0, 1);
    chk("flush_en", 32'(enable_decode), 32'd0);
    chk("flush_cleared_ready", 32'(fetch_ready), 32'd1);
    step(1, 0, '0, '0, 0, 0);
    chk("flush_no_issue", 32'(enable_decode), 32'd0);
    step(1, 1, 16'h1234, 16'h4010, 0, 0);
    step(1, 0, '0, '0, 0, 0);
    chk("flush_next_en", 32'(enable_decode), 32'd1);
    chk("flush_next_dout", 32'(dout), 32'h1234);
    chk("flush_next_npc", 32'(npc_in), 32'h4010);
    step(1, 1, 16'h4444, 16'h4020, 0, 1);
    step(1, 0, '0, '0, 0, 0);
    chk("flush_push_drop", 32'(enable_decode), 32'd0);

    // LDI followed by ADD: bubble gap.
    do_reset();
    t1 = -1; t2 = -1;
    for (int c = 0; c < 12; c++) begin
      if (c == 0)      step(1, 1, 16'hA202, 16'h3001, 0, 0);
      else if (c == 1) step(1, 1, 16'h1021, 16'h3002, 0, 0);
      else             step(1, 0, '0, '0, 0, 0);
      if (enable_decode === 1'b1 && dout == 16'hA202) t1 = c;
      if (enable_decode === 1'b1 && dout == 16'h1021) t2 = c;
    end
    chk("bubble_both_issued", 32'(t1 >= 0 && t2 >= 0), 32'd1);
`ifdef DECODE_ISSUE_BUBBLE_EN
    chk("bubble_gap", 32'(t2 - t1), 32'(MB + 1));
`else
    chk("bubble_gap", 32'(t2 - t1), 32'd1);
`endif

    // Reset while stalled with a full FIFO.
    do_reset();
    step(1, 1, 16'h1111, 16'h4001, 1, 0);
    step(1, 1, 16'h2222, 16'h4002, 1, 0);
    step(0, 1, 16'h3333, 16'h4003, 1, 0);
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_npc", 32'(npc_in), 32'd0);
    chk("rst_en", 32'(enable_decode), 32'd0);
    chk("rst_count", 32'(issue_count), 32'd0);
    chk("rst_ready", 32'(fetch_ready), 32'd0);
    step(1, 0, '0, '0, 0, 0);
    chk("rst_idle_exit_ready", 32'(fetch_ready), 32'd1);
    step(1, 0, '0, '0, 0, 0);
    chk("rst_fifo_empty", 32'(enable_decode), 32'd0);

    // Randomized traffic.
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      step($urandom_range(99) != 0, $urandom_range(3) != 0, 16'($urandom), 16'($urandom),
           $urandom_range(3) == 0, $urandom_range(19) == 0);
    end

    // 65537 issues: counter wraps to 1.
    do_reset();
    pulses = 0;
    for (int c = 0; c < 70000 && pulses < 65537; c++) begin
      step(1, 1, 16'h1000 | 16'(c & 32'h0FFF), 16'(c), 0, 0);
      if (enable_decode === 1'b1) pulses++;
    end
    chk("wrap_pulses", 32'(pulses), 32'd65537);
    chk("wrap_count", 32'(issue_count), 32'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
